// File: rtl/result_post_processor.sv
// Post-processing for accelerator row results: bias add with saturation,
// optional ReLU, optional pairwise max-pooling, and an output FIFO on a bus.
module result_post_processor #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 10,
    parameter int FifoDepth    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ResultValidIn,
    input  logic [DataWidth-1:0]    ResultIn,
    input  logic                    WriteEnIn,
    input  logic                    ReadEnIn,
    input  logic [AddressWidth-1:0] AddressIn,
    input  logic [DataWidth-1:0]    DataIn,
    output logic [DataWidth-1:0]    DataOut,
    output logic                    DataValidOut,
    output logic                    FifoFullOut
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;

    typedef enum logic {
        P_FIRST,
        P_SECOND
    } pool_state_t;

    logic                 w_wr_clr;
    logic                 w_wr_bias;
    logic                 w_wr_ctrl;
    logic                 w_clr;
    logic                 w_pop_req;
    logic                 w_stat_req;

    logic [DataWidth-1:0] r_bias;
    logic                 r_relu_en;
    logic                 r_pool_en;

    logic [DataWidth:0]   w_sum;
    logic [DataWidth-1:0] w_s1_sat;
    logic [DataWidth-1:0] r_s1;
    logic                 r_s1_v;
    logic [DataWidth-1:0] r_s2;
    logic                 r_s2_v;
    logic [DataWidth-1:0] r_s3;
    logic                 r_s3_v;

    pool_state_t          r_state;
    pool_state_t          w_state_nxt;
    logic [DataWidth-1:0] r_held;
    logic                 w_hold;
    logic                 w_push;
    logic [DataWidth-1:0] w_push_data;

    logic [DataWidth-1:0] r_mem [FifoDepth];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [CntW-1:0]      r_count;
    logic                 r_ovf;
    logic                 r_udf;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_ok;
    logic [DataWidth-1:0] w_status;
    logic [DataWidth-1:0] w_rd_data;

    assign w_wr_clr   = WriteEnIn && (AddressIn == AddressWidth'(0));
    assign w_wr_bias  = WriteEnIn && (AddressIn == AddressWidth'(1));
    assign w_wr_ctrl  = WriteEnIn && (AddressIn == AddressWidth'(2));
    assign w_stat_req = ReadEnIn && (AddressIn == AddressWidth'(3));
    assign w_pop_req  = ReadEnIn && (AddressIn == AddressWidth'(4));
    assign w_clr      = reset || w_wr_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bias    <= '0;
            r_relu_en <= 1'b0;
            r_pool_en <= 1'b0;
        end else begin
            if (w_wr_bias) begin
                r_bias <= DataIn;
            end
            if (w_wr_ctrl) begin
                r_relu_en <= DataIn[0];
                r_pool_en <= DataIn[1];
            end
        end
    end

    // Sign-extended sum cannot wrap; saturate when the top two bits differ.
    assign w_sum = {ResultIn[DataWidth-1], ResultIn} + {r_bias[DataWidth-1], r_bias};

    always_comb begin
        w_s1_sat = w_sum[DataWidth-1:0];
        if (w_sum[DataWidth] != w_sum[DataWidth-1]) begin
            w_s1_sat = w_sum[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                        : {1'b0, {(DataWidth-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
            r_s2_v <= 1'b0;
            r_s2   <= '0;
            r_s3_v <= 1'b0;
            r_s3   <= '0;
        end else begin
            r_s1_v <= ResultValidIn;
            r_s1   <= w_s1_sat;
            r_s2_v <= r_s1_v;
            r_s2   <= (r_relu_en && r_s1[DataWidth-1]) ? '0 : r_s1;
            r_s3_v <= w_push;
            r_s3   <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr || w_wr_ctrl) begin
            r_state <= P_FIRST;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hold) begin
                r_held <= r_s2;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_pool_en && r_s2_v) begin
            unique case (r_state)
                P_FIRST:  w_state_nxt = P_SECOND;
                P_SECOND: w_state_nxt = P_FIRST;
                default:  w_state_nxt = P_FIRST;
            endcase
        end
    end

    always_comb begin
        w_hold      = 1'b0;
        w_push      = 1'b0;
        w_push_data = r_s2;
        if (r_s2_v) begin
            if (!r_pool_en) begin
                w_push = 1'b1;
            end else if (r_state == P_FIRST) begin
                w_hold = 1'b1;
            end else begin
                w_push = 1'b1;
                if ($signed(r_held) > $signed(r_s2)) begin
                    w_push_data = r_held;
                end
            end
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CntW'(FifoDepth));
    assign w_pop     = w_pop_req && !w_empty;
    assign w_push_ok = r_s3_v && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= r_s3;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
            if (r_s3_v && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (w_pop_req && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    always_comb begin
        w_status             = '0;
        w_status[8 +: CntW]  = r_count;
        w_status[3]          = r_udf;
        w_status[2]          = r_ovf;
        w_status[1]          = w_full;
        w_status[0]          = w_empty;
    end

    always_comb begin
        w_rd_data = '0;
        if (w_pop) begin
            w_rd_data = r_mem[r_rptr];
        end else if (w_stat_req) begin
            w_rd_data = w_status;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            DataOut      <= '0;
            DataValidOut <= 1'b0;
        end else begin
            DataOut      <= w_rd_data;
            DataValidOut <= ReadEnIn;
        end
    end

    assign FifoFullOut = w_full;

endmodule

// File: tb/tb_result_post_processor.sv
// Directed bench for result_post_processor: hand-computed expectations
// checked with immediate assertions after each bus read.
module tb_result_post_processor;

    logic        clk = 1'b0;
    logic        reset;
    logic        ResultValidIn;
    logic [31:0] ResultIn;
    logic        WriteEnIn;
    logic        ReadEnIn;
    logic [9:0]  AddressIn;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        DataValidOut;
    logic        FifoFullOut;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rdat;
    logic        rval;

    result_post_processor dut (
        .clk          (clk),
        .reset        (reset),
        .ResultValidIn(ResultValidIn),
        .ResultIn     (ResultIn),
        .WriteEnIn    (WriteEnIn),
        .ReadEnIn     (ReadEnIn),
        .AddressIn    (AddressIn),
        .DataIn       (DataIn),
        .DataOut      (DataOut),
        .DataValidOut (DataValidOut),
        .FifoFullOut  (FifoFullOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        AddressIn = a;
        DataIn    = d;
        WriteEnIn = 1'b1;
        tick();
        WriteEnIn = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d,
                      output logic v);
        AddressIn = a;
        ReadEnIn  = 1'b1;
        tick();
        ReadEnIn  = 1'b0;
        d = DataOut;
        v = DataValidOut;
    endtask

    task automatic send(input logic [31:0] x);
        ResultIn      = x;
        ResultValidIn = 1'b1;
        tick();
        ResultValidIn = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        rd(10'h004, rdat, rval);
        chk({tag, "_data"}, rdat, exp);
        chk({tag, "_valid"}, {31'b0, rval}, 32'd1);
    endtask

    task automatic stat_chk(input string tag, input logic [31:0] exp);
        rd(10'h003, rdat, rval);
        chk(tag, rdat, exp);
    endtask

    initial begin
        reset         = 1'b1;
        ResultValidIn = 1'b0;
        ResultIn      = '0;
        WriteEnIn     = 1'b0;
        ReadEnIn      = 1'b0;
        AddressIn     = '0;
        DataIn        = '0;
        tick();
        tick();
        chk("rst_dout", DataOut, 32'd0);
        chk("rst_dval", {31'b0, DataValidOut}, 32'd0);
        chk("rst_full", {31'b0, FifoFullOut}, 32'd0);
        reset = 1'b0;
        stat_chk("rst_status", 32'h0000_0001);

        // pass-through and latency: count seen 0,0,1,2 at N+2..N+5
        send(32'hFFFF_FFFB);
        send(32'd7);
        stat_chk("lat_n2", 32'h0000_0001);
        stat_chk("lat_n3", 32'h0000_0001);
        stat_chk("lat_n4", 32'h0000_0100);
        stat_chk("lat_n5", 32'h0000_0200);
        pop_chk("pt0", 32'hFFFF_FFFB);
        pop_chk("pt1", 32'd7);
        stat_chk("pt_empty", 32'h0000_0001);

        // bias, relu, saturation
        wr(10'h001, 32'd10);
        wr(10'h002, 32'd1);
        send(32'hFFFF_FFEC);
        send(32'h7FFF_FFFF);
        repeat (4) tick();
        pop_chk("relu0", 32'd0);
        pop_chk("satpos", 32'h7FFF_FFFF);
        wr(10'h002, 32'd0);
        send(32'hFFFF_FFEC);
        wr(10'h001, 32'hFFFF_FFF6);
        send(32'h8000_0000);
        repeat (4) tick();
        pop_chk("norelu", 32'hFFFF_FFF6);
        pop_chk("satneg", 32'h8000_0000);
        wr(10'h001, 32'd0);

        // pooling
        wr(10'h002, 32'd2);
        send(32'd3);
        send(32'd9);
        send(32'hFFFF_FFFC);
        send(32'hFFFF_FFFF);
        repeat (4) tick();
        stat_chk("pool_cnt", 32'h0000_0200);
        pop_chk("pool0", 32'd9);
        pop_chk("pool1", 32'hFFFF_FFFF);
        wr(10'h002, 32'd0);

        // overflow then underflow
        for (int i = 1; i <= 17; i++) send(32'(i));
        repeat (4) tick();
        chk("ovf_full", {31'b0, FifoFullOut}, 32'd1);
        stat_chk("ovf_status", 32'h0000_1006);
        for (int i = 1; i <= 16; i++) pop_chk("ovf_pop", 32'(i));
        pop_chk("udf_pop", 32'd0);
        stat_chk("udf_status", 32'h0000_000D);

        // soft clear, then push+pop on a full FIFO
        wr(10'h000, 32'h1234_5678);
        stat_chk("clr_status", 32'h0000_0001);
        for (int i = 101; i <= 116; i++) send(32'(i));
        repeat (4) tick();
        send(32'd200);
        tick();
        tick();
        pop_chk("fullpp", 32'd101);
        stat_chk("fullpp_status", 32'h0000_1002);
        for (int i = 102; i <= 116; i++) pop_chk("fullpp_drain", 32'(i));
        pop_chk("fullpp_last", 32'd200);

        // push+pop on an empty FIFO
        wr(10'h000, 32'd0);
        send(32'd300);
        tick();
        tick();
        pop_chk("emptypp", 32'd0);
        stat_chk("emptypp_status", 32'h0000_0108);
        pop_chk("emptypp_val", 32'd300);

        // unmapped accesses
        wr(10'h000, 32'd0);
        wr(10'h007, 32'hFFFF_FFFF);
        rd(10'h3FF, rdat, rval);
        chk("unmap_data", rdat, 32'd0);
        chk("unmap_valid", {31'b0, rval}, 32'd1);
        rd(10'h001, rdat, rval);
        chk("bias_wo", rdat, 32'd0);

        // soft clear with queued entries and a held pooled value
        for (int i = 1; i <= 5; i++) send(32'(i));
        repeat (4) tick();
        stat_chk("sc_cnt5", 32'h0000_0500);
        wr(10'h002, 32'd2);
        send(32'd50);
        repeat (4) tick();
        wr(10'h001, 32'd1);
        wr(10'h000, 32'd0);
        stat_chk("sc_status", 32'h0000_0001);
        send(32'd7);
        send(32'd3);
        repeat (4) tick();
        stat_chk("sc_single", 32'h0000_0100);
        pop_chk("sc_max", 32'd8);

        // reset in the middle of a burst
        wr(10'h002, 32'd1);
        wr(10'h001, 32'd5);
        ResultValidIn = 1'b1;
        ResultIn      = 32'd11;
        tick();
        ResultIn      = 32'd12;
        tick();
        reset         = 1'b1;
        ResultIn      = 32'd13;
        tick();
        ResultIn      = 32'd14;
        tick();
        reset         = 1'b0;
        ResultValidIn = 1'b0;
        repeat (5) tick();
        stat_chk("rst_burst", 32'h0000_0001);
        send(32'hFFFF_FFFD);
        repeat (4) tick();
        pop_chk("rst_cfg", 32'hFFFF_FFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
